// File: rtl/fsram_pingpong_sched_if.sv
// Control handshake bundle for the fsram ping-pong scheduler.
// Carries layer start, writer/reader valid-ready and layer status.
interface fsram_pingpong_sched_if #(
  parameter int TILE_CNT_W = 8
);
  logic                  start;
  logic [TILE_CNT_W-1:0] num_tiles;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  busy;
  logic                  done;

  modport master (
    output start, num_tiles,
    output wr_valid, rd_valid,
    input  wr_ready, rd_ready,
    input  busy, done
  );

  modport slave (
    input  start, num_tiles,
    input  wr_valid, rd_valid,
    output wr_ready, rd_ready,
    output busy, done
  );
endinterface

// File: rtl/fsram_pingpong_sched.sv
// Ping-pong scheduler for the two feature SRAM banks (fill on A, feed on B).
// Optional stall counters are built when SCHED_PERF_CNT_EN is defined.
module fsram_pingpong_sched #(
  parameter int ADDR_W     = 11,
  parameter int TILE_DEPTH = 1024,
  parameter int TILE_CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  fsram_pingpong_sched_if.slave ctl,
  output logic              CENA_1,
  output logic              WENA_1,
  output logic [ADDR_W-1:0] AA_1,
  output logic              CENB_1,
  output logic [ADDR_W-1:0] AB_1,
  output logic              CENA_2,
  output logic              WENA_2,
  output logic [ADDR_W-1:0] AA_2,
  output logic              CENB_2,
  output logic [ADDR_W-1:0] AB_2,
  output logic              sram_sel1,
  output logic              sram_sel2,
  output logic              rd_data_valid,
  output logic [15:0]       wr_stall_cnt,
  output logic [15:0]       rd_stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DONE
  } top_t;

  typedef enum logic [1:0] {
    B_EMPTY, B_FILLING, B_FULL, B_DRAINING
  } bank_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(TILE_DEPTH - 1);
  localparam logic [TILE_CNT_W-1:0] ONE_T =
    TILE_CNT_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A =
    ADDR_W'(1);

  top_t                  state;
  bank_t                 bank [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [ADDR_W-1:0]     wr_addr;
  logic [ADDR_W-1:0]     rd_addr;
  logic [TILE_CNT_W-1:0] wr_left;
  logic [TILE_CNT_W-1:0] rd_left;

  logic  run;
  logic  go;
  bank_t wbk;
  bank_t rbk;
  logic  wr_ok;
  logic  rd_ok;
  logic  wr_fire;
  logic  rd_fire;
  logic  wr_last;
  logic  rd_last;

  assign run   = (state == S_RUN);
  assign go    = (state == S_IDLE) && ctl.start
              && (ctl.num_tiles != '0);
  assign wbk   = bank[wr_ptr];
  assign rbk   = bank[rd_ptr];
  // Bank states are mutually exclusive, so the two ports never meet.
  assign wr_ok = run && (wr_left != '0)
              && (wbk == B_EMPTY || wbk == B_FILLING);
  assign rd_ok = run
              && (rbk == B_FULL || rbk == B_DRAINING);

  assign wr_fire = ctl.wr_valid && wr_ok;
  assign rd_fire = ctl.rd_valid && rd_ok;
  assign wr_last = wr_fire && (wr_addr == LAST);
  assign rd_last = rd_fire && (rd_addr == LAST);

  assign ctl.wr_ready = wr_ok;
  assign ctl.rd_ready = rd_ok;
  assign ctl.busy     = run;
  assign ctl.done     = (state == S_DONE);

  assign CENA_1 = ~(wr_fire & ~wr_ptr);
  assign WENA_1 = ~(wr_fire & ~wr_ptr);
  assign AA_1   = wr_ptr ? '0 : wr_addr;
  assign CENA_2 = ~(wr_fire & wr_ptr);
  assign WENA_2 = ~(wr_fire & wr_ptr);
  assign AA_2   = wr_ptr ? wr_addr : '0;

  assign CENB_1 = ~(rd_fire & ~rd_ptr);
  assign AB_1   = rd_ptr ? '0 : rd_addr;
  assign CENB_2 = ~(rd_fire & rd_ptr);
  assign AB_2   = rd_ptr ? rd_addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bank[0]       <= B_EMPTY;
      bank[1]       <= B_EMPTY;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_addr       <= '0;
      rd_addr       <= '0;
      wr_left       <= '0;
      rd_left       <= '0;
      rd_data_valid <= 1'b0;
      sram_sel1     <= 1'b0;
      sram_sel2     <= 1'b0;
    end else begin
      // QB arrives one cycle after the read; align the select with it.
      rd_data_valid <= rd_fire;
      sram_sel1     <= rd_fire & ~rd_ptr;
      sram_sel2     <= rd_fire & rd_ptr;

      unique case (state)
        S_IDLE: begin
          if (go) begin
            state   <= S_RUN;
            wr_left <= ctl.num_tiles;
            rd_left <= ctl.num_tiles;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            wr_addr <= '0;
            rd_addr <= '0;
          end
        end
        S_RUN: begin
          if (rd_last && rd_left == ONE_T)
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase

      if (wr_fire) begin
        if (wr_last) begin
          bank[wr_ptr] <= B_FULL;
          wr_addr      <= '0;
          wr_ptr       <= ~wr_ptr;
          wr_left      <= wr_left - ONE_T;
        end else begin
          bank[wr_ptr] <= B_FILLING;
          wr_addr      <= wr_addr + ONE_A;
        end
      end

      if (rd_fire) begin
        if (rd_last) begin
          bank[rd_ptr] <= B_EMPTY;
          rd_addr      <= '0;
          rd_ptr       <= ~rd_ptr;
          rd_left      <= rd_left - ONE_T;
        end else begin
          bank[rd_ptr] <= B_DRAINING;
          rd_addr      <= rd_addr + ONE_A;
        end
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [15:0] wsc;
  logic [15:0] rsc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsc <= '0;
      rsc <= '0;
    end else if (go) begin
      wsc <= '0;
      rsc <= '0;
    end else begin
      if (run && ctl.wr_valid && !wr_ok
          && wsc != 16'hFFFF)
        wsc <= wsc + 16'd1;
      if (run && ctl.rd_valid && !rd_ok
          && rsc != 16'hFFFF)
        rsc <= rsc + 16'd1;
    end
  end

  assign wr_stall_cnt = wsc;
  assign rd_stall_cnt = rsc;
`else
  assign wr_stall_cnt = '0;
  assign rd_stall_cnt = '0;
`endif

endmodule
